axi_lite_op_master: RTL and testbench

- AXI4-Lite master that drives the arithmetic register slave (srcA @0x00, srcB @0x04, add @0x08, sub @0x0C, mult @0x10) on behalf of a local command stream.
- Accepts one command {op, srcA, srcB} on a valid/ready port, writes srcA then srcB, waits one settle cycle, reads the selected result and returns it on a valid/ready response port.
- Sits directly upstream of the register slave. Its M_AXI_LITE_* ports connect 1:1 to the slave's S_AXI_LITE_* ports.

---
 rtl/axi_lite_op_master.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_op_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_op_master.sv
// axi_lite_op_master: AXI4-Lite master that writes two operands to the arithmetic slave and reads back one result.
// Optional per-phase watchdog enabled by defining AXI_LITE_MST_TIMEOUT_EN.
`default_nettype none

module axi_lite_op_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [DATA_WIDTH-1:0]   cmd_srcA,
    input  logic [DATA_WIDTH-1:0]   cmd_srcB,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_awaddr,
    output logic                    M_AXI_LITE_awvalid,
    input  logic                    M_AXI_LITE_awready,
    output logic [DATA_WIDTH-1:0]   M_AXI_LITE_wdata,
    output logic [DATA_WIDTH/8-1:0] M_AXI_LITE_wstrb,
    output logic                    M_AXI_LITE_wvalid,
    input  logic                    M_AXI_LITE_wready,
    input  logic [1:0]              M_AXI_LITE_bresp,
    input  logic                    M_AXI_LITE_bvalid,
    output logic                    M_AXI_LITE_bready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_araddr,
    output logic                    M_AXI_LITE_arvalid,
    input  logic                    M_AXI_LITE_arready,
    input  logic [DATA_WIDTH-1:0]   M_AXI_LITE_rdata,
    input  logic [1:0]              M_AXI_LITE_rresp,
    input  logic                    M_AXI_LITE_rvalid,
    output logic                    M_AXI_LITE_rready
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("axi_lite_op_master: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axi_lite_op_master: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR     = 3'd1;
    localparam logic [2:0] S_WRESP  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RADDR  = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    logic [2:0]            state_q, state_d;
    logic                  wr_idx_q, wr_idx_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  err_q, err_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] srcb_q, srcb_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic                  tmo_hit;

`ifdef AXI_LITE_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             waiting;

    assign waiting = (state_q == S_WR) || (state_q == S_WRESP) ||
                     (state_q == S_RADDR) || (state_q == S_RDATA);
    assign tmo_hit = waiting && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tmo_cnt_q <= '0;
        end else if ((state_d != state_q) || !waiting) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        case (op_q)
            2'd0:    rd_off = ADDR_WIDTH'(32'h08);
            2'd1:    rd_off = ADDR_WIDTH'(32'h0C);
            2'd2:    rd_off = ADDR_WIDTH'(32'h10);
            default: rd_off = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        err_d      = err_q;
        op_d       = op_q;
        srcb_d     = srcb_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    srcb_d    = cmd_srcB;
                    err_d     = 1'b0;
                    wr_idx_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = ADDR_WIDTH'(BASE_ADDR);
                    wdata_d   = cmd_srcA;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                // Done flags are sticky so AW and W may complete in either order.
                aw_done_d = aw_done_q | M_AXI_LITE_awready;
                w_done_d  = w_done_q | M_AXI_LITE_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (M_AXI_LITE_bvalid) begin
                    err_d     = err_q | (M_AXI_LITE_bresp != 2'b00);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (!wr_idx_q) begin
                        wr_idx_d = 1'b1;
                        awaddr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(32'h04);
                        wdata_d  = srcb_q;
                        state_d  = S_WR;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                araddr_d = ADDR_WIDTH'(BASE_ADDR) + rd_off;
                state_d  = S_RADDR;
            end
            S_RADDR: begin
                if (M_AXI_LITE_arready) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (M_AXI_LITE_rvalid) begin
                    rsp_data_d = M_AXI_LITE_rdata;
                    err_d      = err_q | (M_AXI_LITE_rresp != 2'b00);
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    wr_idx_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d    = S_RESP;
            err_d      = 1'b1;
            rsp_data_d = '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            wr_idx_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err_q      <= 1'b0;
            op_q       <= 2'd0;
            srcb_q     <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            err_q      <= err_d;
            op_q       <= op_d;
            srcb_q     <= srcb_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign cmd_ready          = (state_q == S_IDLE);
    assign busy               = (state_q != S_IDLE);
    assign rsp_valid          = (state_q == S_RESP);
    assign rsp_err            = (state_q == S_RESP) && err_q;
    assign rsp_data           = rsp_data_q;
    assign M_AXI_LITE_awaddr  = awaddr_q;
    assign M_AXI_LITE_awvalid = (state_q == S_WR) && !aw_done_q;
    assign M_AXI_LITE_wdata   = wdata_q;
    assign M_AXI_LITE_wstrb   = '1;
    assign M_AXI_LITE_wvalid  = (state_q == S_WR) && !w_done_q;
    assign M_AXI_LITE_bready  = (state_q == S_WRESP);
    assign M_AXI_LITE_araddr  = araddr_q;
    assign M_AXI_LITE_arvalid = (state_q == S_RADDR);
    assign M_AXI_LITE_rready  = (state_q == S_RDATA);

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_op_master.sv
// Directed bench for axi_lite_op_master with a behavioural arithmetic-register slave.
`default_nettype none

module tb_axi_lite_op_master;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [DW-1:0] cmd_srcA = '0, cmd_srcB = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_lite_op_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .M_AXI_LITE_awaddr(awaddr), .M_AXI_LITE_awvalid(awvalid), .M_AXI_LITE_awready(awready),
        .M_AXI_LITE_wdata(wdata), .M_AXI_LITE_wstrb(wstrb), .M_AXI_LITE_wvalid(wvalid),
        .M_AXI_LITE_wready(wready),
        .M_AXI_LITE_bresp(bresp), .M_AXI_LITE_bvalid(bvalid), .M_AXI_LITE_bready(bready),
        .M_AXI_LITE_araddr(araddr), .M_AXI_LITE_arvalid(arvalid), .M_AXI_LITE_arready(arready),
        .M_AXI_LITE_rdata(rdata), .M_AXI_LITE_rresp(rresp), .M_AXI_LITE_rvalid(rvalid),
        .M_AXI_LITE_rready(rready)
    );

    // ---------------- behavioural slave ----------------
    int          w_delay = 0;
    bit          berr_second = 1'b0, r_stall = 1'b0, ar_stall = 1'b0;
    logic [31:0] s_a, s_b, w_data_q, r_data_q;
    logic [AW-1:0] aw_addr_q;
    logic        aw_got, w_got, first_cyc, s_bvalid, r_pend;
    logic [1:0]  s_bresp;
    logic [7:0]  wr_count;
    int          wcnt;
    logic [AW-1:0] log_addr [2];
    logic [31:0]   log_data [2];

    wire aw_fire = awvalid && awready;
    wire w_fire  = wvalid && wready;
    wire have_aw = aw_got || aw_fire;
    wire have_w  = w_got || w_fire;
    wire [AW-1:0] addr_eff = aw_got ? aw_addr_q : awaddr;
    wire [31:0]   data_eff = w_got ? w_data_q : wdata;

    assign awready = !first_cyc && !aw_got && !s_bvalid;
    assign wready  = !w_got && !s_bvalid && ((w_delay == 0) || (aw_got && (wcnt >= w_delay - 1)));
    assign bvalid  = s_bvalid;
    assign bresp   = s_bresp;
    assign arready = !ar_stall && !r_pend;
    assign rvalid  = r_pend && !r_stall;
    assign rdata   = r_data_q;
    assign rresp   = 2'b00;

    function automatic logic [31:0] rd_val(input logic [AW-1:0] a);
        case (a)
            8'h00:   rd_val = s_a;
            8'h04:   rd_val = s_b;
            8'h08:   rd_val = s_a + s_b;
            8'h0C:   rd_val = s_a - s_b;
            8'h10:   rd_val = s_a * s_b;
            default: rd_val = 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            first_cyc <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0;
            r_pend <= 1'b0; s_bresp <= 2'b00; wr_count <= 8'd0; wcnt <= 0;
            s_a <= '0; s_b <= '0; aw_addr_q <= '0; w_data_q <= '0; r_data_q <= '0;
        end else begin
            first_cyc <= 1'b0;
            if (have_aw && have_w) begin
                if (addr_eff == 8'h00) s_a <= data_eff;
                else if (addr_eff == 8'h04) s_b <= data_eff;
                log_addr[wr_count[0]] <= addr_eff;
                log_data[wr_count[0]] <= data_eff;
                s_bresp  <= (berr_second && wr_count[0]) ? 2'b10 : 2'b00;
                s_bvalid <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                wr_count <= wr_count + 8'd1;
            end else begin
                if (aw_fire) begin
                    aw_got <= 1'b1; aw_addr_q <= awaddr; wcnt <= 0;
                end else if (aw_got) begin
                    wcnt <= wcnt + 1;
                end
                if (w_fire) begin
                    w_got <= 1'b1; w_data_q <= wdata;
                end
            end
            if (s_bvalid && bready) s_bvalid <= 1'b0;
            if (arvalid && arready) begin
                r_pend <= 1'b1; r_data_q <= rd_val(araddr);
            end
            if (rvalid && rready) r_pend <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_op = op; cmd_srcA = a; cmd_srcB = b;
        while (!cmd_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_ready_at_send", {63'd0, cmd_ready}, 64'd1);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    // Returns the cycle index (accept cycle = 1) in which rsp_valid is first seen.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 300) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic consume();
        @(negedge aclk);
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1 rsp_ready = 1'b0;
        check("rsp_valid_after_consume", {63'd0, rsp_valid}, 64'd0);
        check("cmd_ready_after_consume", {63'd0, cmd_ready}, 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int n;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_ctrl", {56'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, busy}, 64'd0);
        check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("reset_addr_data", {16'd0, awaddr, araddr, wdata}, 64'd0);
        check("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
        areset = 1'b0;

        // add 7 + 5 with a zero-wait slave
        send(2'd0, 32'd7, 32'd5);
        check("wr0_valids", {62'd0, awvalid, wvalid}, 64'd3);
        check("wr0_addr", {56'd0, awaddr}, 64'h00);
        check("wr0_data", {32'd0, wdata}, 64'd7);
        check("wstrb", {60'd0, wstrb}, 64'hF);
        wait_rsp(lat);
        check("add_latency", 64'(lat), 64'd8);
        check("add_data", {32'd0, rsp_data}, 64'd12);
        check("add_err", {63'd0, rsp_err}, 64'd0);
        check("add_log_a0", {56'd0, log_addr[0]}, 64'h00);
        check("add_log_d0", {32'd0, log_data[0]}, 64'd7);
        check("add_log_a1", {56'd0, log_addr[1]}, 64'h04);
        check("add_log_d1", {32'd0, log_data[1]}, 64'd5);
        consume();

        // sub 3 - 10, response held for five cycles
        send(2'd1, 32'd3, 32'd10);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            check("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_data", {32'd0, rsp_data}, 64'hFFFF_FFF9);
            check("hold_err", {63'd0, rsp_err}, 64'd0);
            check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        end
        consume();

        // mult -4 * 6
        send(2'd2, 32'hFFFF_FFFC, 32'd6);
        wait_rsp(lat);
        check("mult_data", {32'd0, rsp_data}, 64'hFFFF_FFE8);
        check("mult_err", {63'd0, rsp_err}, 64'd0);
        consume();

        // W lags AW by three cycles, second write answers SLVERR
        w_delay = 3; berr_second = 1'b1;
        send(2'd0, 32'd100, 32'd23);
        wait_rsp(lat);
        check("slow_data", {32'd0, rsp_data}, 64'd123);
        check("slow_err", {63'd0, rsp_err}, 64'd1);
        check("slow_log_d1", {32'd0, log_data[1]}, 64'd23);
        consume();
        w_delay = 0; berr_second = 1'b0;

        // readback of srcA; error flag must be clear again
        send(2'd3, 32'h1234_5678, 32'h0BAD_F00D);
        wait_rsp(lat);
        check("rdback_data", {32'd0, rsp_data}, 64'h1234_5678);
        check("rdback_err", {63'd0, rsp_err}, 64'd0);
        consume();

        // reset while waiting in the read-data phase
        r_stall = 1'b1;
        send(2'd1, 32'd9, 32'd4);
        n = 0;
        while (!rready && n < 50) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("in_rdata", {63'd0, rready}, 64'd1);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        check("midrst_ctrl", {56'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, busy}, 64'd0);
        check("midrst_addr", {48'd0, awaddr, araddr}, 64'd0);
        check("midrst_data", {wdata, rsp_data}, 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        r_stall = 1'b0;
        send(2'd1, 32'd50, 32'd8);
        wait_rsp(lat);
        check("post_rst_data", {32'd0, rsp_data}, 64'd42);
        check("post_rst_err", {63'd0, rsp_err}, 64'd0);
        consume();

`ifdef AXI_LITE_MST_TIMEOUT_EN
        // arready stuck low: 5 write/settle cycles, 16 in RADDR, then RESP
        ar_stall = 1'b1;
        send(2'd2, 32'd3, 32'd4);
        wait_rsp(lat);
        check("tmo_latency", 64'(lat), 64'd22);
        check("tmo_data", {32'd0, rsp_data}, 64'd0);
        check("tmo_err", {63'd0, rsp_err}, 64'd1);
        check("tmo_arvalid", {63'd0, arvalid}, 64'd0);
        consume();
        ar_stall = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
